// File: rtl/mem_port_arbiter.sv
// Shared single-port memory arbiter between instruction fetch (IF) and the MEM stage.
// MEM has priority; IF is force-granted once it has lost starve_limit arbitrations in a row.
//
// state  | meaning
// IDLE   | no read in flight
// RD_IF  | fetch read issued last cycle, ram_rdata belongs to IF
// RD_MEM | load issued last cycle, ram_rdata belongs to MEM
module mem_port_arbiter #(
  parameter int data_bits           = 32,
  parameter int memory_address_bits = 10,
  parameter int starve_limit        = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           if_req,
  input  logic [memory_address_bits-1:0] if_addr,
  output logic                           if_stall,
  output logic                           if_valid,
  output logic [data_bits-1:0]           if_rdata,
  input  logic                           mem_req,
  input  logic                           mem_we,
  input  logic [memory_address_bits-1:0] mem_addr,
  input  logic [data_bits-1:0]           mem_wdata,
  output logic                           mem_stall,
  output logic                           mem_valid,
  output logic [data_bits-1:0]           mem_rdata,
  output logic                           ram_en,
  output logic                           ram_we,
  output logic [memory_address_bits-1:0] ram_addr,
  output logic [data_bits-1:0]           ram_wdata,
  input  logic [data_bits-1:0]           ram_rdata,
  output logic [15:0]                    conflict_count
);

  localparam int starve_bits = (starve_limit < 1) ? 1 : $clog2(starve_limit + 1);
  localparam logic [starve_bits-1:0] starve_max = starve_bits'(starve_limit);
  localparam logic [starve_bits-1:0] starve_one = starve_bits'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_IF  = 2'd1,
    RD_MEM = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [starve_bits-1:0]  starve_cnt, starve_next;
  logic                    grant_if, grant_mem;
  logic [data_bits-1:0]    if_rdata_q, mem_rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      starve_cnt     <= '0;
      conflict_count <= '0;
      if_rdata_q     <= '0;
      mem_rdata_q    <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
      if (if_req && mem_req && conflict_count != 16'hFFFF)
        conflict_count <= conflict_count + 16'd1;
      if (state == RD_IF)
        if_rdata_q <= ram_rdata;
      if (state == RD_MEM)
        mem_rdata_q <= ram_rdata;
    end
  end

  // Grant is purely combinational; reset masks every request so nothing reaches the RAM.
  always_comb begin
    grant_if    = 1'b0;
    grant_mem   = 1'b0;
    state_next  = IDLE;
    starve_next = '0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;

    if (!reset) begin
      if (if_req && mem_req) begin
        if (starve_cnt == starve_max) grant_if  = 1'b1;
        else                          grant_mem = 1'b1;
      end else if (mem_req) begin
        grant_mem = 1'b1;
      end else if (if_req) begin
        grant_if = 1'b1;
      end
    end

    if (grant_if) begin
      ram_en     = 1'b1;
      ram_addr   = if_addr;
      state_next = RD_IF;
    end else if (grant_mem) begin
      ram_en    = 1'b1;
      ram_we    = mem_we;
      ram_addr  = mem_addr;
      ram_wdata = mem_wdata;
      if (!mem_we) state_next = RD_MEM;
    end

    if (if_req && grant_mem)
      starve_next = (starve_cnt == starve_max) ? starve_cnt : starve_cnt + starve_one;

    if_stall  = if_req  && !grant_if  && !reset;
    mem_stall = mem_req && !grant_mem && !reset;
  end

  assign if_valid  = (state == RD_IF);
  assign mem_valid = (state == RD_MEM);
  assign if_rdata  = if_valid  ? ram_rdata : if_rdata_q;
  assign mem_rdata = mem_valid ? ram_rdata : mem_rdata_q;

endmodule
